simd_cmp_pipe: RTL and testbench

//  Pipelined, parametrised SIMD comparator: lane-wise EQ / signed GT / unsigned GT / signed LT on WIDTH-bit vectors.

---
 rtl/simd_cmp_pkg.sv | 37 +++
 rtl/simd_cmp_lane_merge.sv | 78 +++++++
 rtl/simd_cmp_pipe.sv | 115 +++++++++++
 tb/tb_simd_cmp_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/simd_cmp_pkg.sv
// Shared types and lane helpers for the SIMD comparator pipeline.
package simd_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ  = 2'd0,
    CMP_GTS = 2'd1,
    CMP_GTU = 2'd2,
    CMP_LTS = 2'd3
  } cmp_op_e;

  typedef enum logic [2:0] {
    LANE_8   = 3'd0,
    LANE_16  = 3'd1,
    LANE_32  = 3'd2,
    LANE_64  = 3'd3,
    LANE_128 = 3'd4,
    LANE_256 = 3'd5
  } lane_mode_e;

  typedef struct packed {
    logic [2:0] mode;
    cmp_op_e    op;
  } cmp_ctrl_t;

  // log2 of bytes per lane: modes above 256-bit lanes alias to 256, then clamp to the vector.
  function automatic int unsigned eff_mode(input logic [2:0] mode, input int unsigned width);
    int unsigned cap;
    cap = $clog2(width / 8);
    if (cap > 32'(LANE_256)) cap = 32'(LANE_256);
    return (32'(mode) > cap) ? cap : 32'(mode);
  endfunction

  function automatic int unsigned lane_count(input logic [2:0] mode, input int unsigned width);
    return (width / 8) >> eff_mode(mode, width);
  endfunction

endpackage

// File: rtl/simd_cmp_lane_merge.sv
// Merges registered per-byte compare partials into lane results for one mode/op.
// Optional mask output under SIMD_CMP_MASK_EN.
module simd_cmp_lane_merge
  import simd_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 256
) (
  input  logic [WIDTH/8-1:0] eq,
  input  logic [WIDTH/8-1:0] gtu,
  input  logic [WIDTH/8-1:0] ltu,
  input  logic [WIDTH/8-1:0] sign_a,
  input  logic [WIDTH/8-1:0] sign_b,
  input  logic [2:0]         mode,
  input  cmp_op_e            op,
  output logic [WIDTH-1:0]   res
`ifdef SIMD_CMP_MASK_EN
  ,
  output logic [WIDTH/8-1:0] mask
`endif
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  int unsigned   m;
  int unsigned   lb_m1;
  int unsigned   nl;
  logic          eq_acc;
  logic          gt_acc;
  logic          lt_acc;
  logic          hit;
  logic [NB-1:0] lane_raw;
  logic [NB-1:0] lane_mask;

  // Scan bytes LSB->MSB inside each lane; a non-equal higher byte overrides lower ones.
  always_comb begin
    m         = eff_mode(mode, WIDTH);
    lb_m1     = (32'd1 << m) - 32'd1;
    nl        = lane_count(mode, WIDTH);
    eq_acc    = 1'b1;
    gt_acc    = 1'b0;
    lt_acc    = 1'b0;
    hit       = 1'b0;
    lane_raw  = '0;
    lane_mask = '0;
    res       = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if ((k & lb_m1) == 32'd0) begin
        eq_acc = 1'b1;
        gt_acc = 1'b0;
        lt_acc = 1'b0;
      end
      eq_acc = eq_acc & eq[k];
      gt_acc = gtu[k] | (eq[k] & gt_acc);
      lt_acc = ltu[k] | (eq[k] & lt_acc);
      if ((k & lb_m1) == lb_m1) begin
        case (op)
          CMP_EQ:  hit = eq_acc;
          CMP_GTS: hit = (sign_a[k] != sign_b[k]) ? sign_b[k] : gt_acc;
          CMP_GTU: hit = gt_acc;
          default: hit = (sign_a[k] != sign_b[k]) ? sign_a[k] : lt_acc;
        endcase
        lane_raw[IW'(k >> m)] = hit;
      end
    end
    for (int unsigned l = 0; l < NB; l++) begin
      if (l < nl) lane_mask[l] = lane_raw[l];
    end
    for (int unsigned k = 0; k < NB; k++) begin
      res[8*k +: 8] = {8{lane_mask[IW'(k >> m)]}};
    end
  end

`ifdef SIMD_CMP_MASK_EN
  assign mask = lane_mask;
`endif

endmodule

// File: rtl/simd_cmp_pipe.sv
// Two-stage pipelined SIMD comparator with valid/ready on both sides.
// Optional per-lane out_mask port under SIMD_CMP_MASK_EN.
module simd_cmp_pipe
  import simd_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_mode,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_res,
  output logic [TAG_W-1:0]   out_tag
`ifdef SIMD_CMP_MASK_EN
  ,
  output logic [WIDTH/8-1:0] out_mask
`endif
);

  localparam int unsigned NB = WIDTH / 8;

  logic [NB-1:0]    eq_c, gtu_c, ltu_c, sa_c, sb_c;
  logic             s1_valid;
  logic [NB-1:0]    s1_eq, s1_gtu, s1_ltu, s1_sa, s1_sb;
  cmp_ctrl_t        s1_ctrl;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_en, s2_en;
  logic [WIDTH-1:0] mg_res;
`ifdef SIMD_CMP_MASK_EN
  logic [NB-1:0]    mg_mask;
`endif

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  // Per-byte unsigned partials and byte sign bits.
  always_comb begin
    eq_c  = '0;
    gtu_c = '0;
    ltu_c = '0;
    sa_c  = '0;
    sb_c  = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      eq_c[k]  = in_a[8*k +: 8] == in_b[8*k +: 8];
      gtu_c[k] = in_a[8*k +: 8] >  in_b[8*k +: 8];
      ltu_c[k] = in_a[8*k +: 8] <  in_b[8*k +: 8];
      sa_c[k]  = in_a[8*k + 7];
      sb_c[k]  = in_b[8*k + 7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_eq        <= eq_c;
        s1_gtu       <= gtu_c;
        s1_ltu       <= ltu_c;
        s1_sa        <= sa_c;
        s1_sb        <= sb_c;
        s1_ctrl.mode <= in_mode;
        s1_ctrl.op   <= cmp_op_e'(in_op);
        s1_tag       <= in_tag;
      end
    end
  end

  simd_cmp_lane_merge #(.WIDTH(WIDTH)) u_merge (
    .eq     (s1_eq),
    .gtu    (s1_gtu),
    .ltu    (s1_ltu),
    .sign_a (s1_sa),
    .sign_b (s1_sb),
    .mode   (s1_ctrl.mode),
    .op     (s1_ctrl.op),
    .res    (mg_res)
`ifdef SIMD_CMP_MASK_EN
    ,
    .mask   (mg_mask)
`endif
  );

  // Output stage holds its beat while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_tag   <= '0;
`ifdef SIMD_CMP_MASK_EN
      out_mask  <= '0;
`endif
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_res  <= mg_res;
        out_tag  <= s1_tag;
`ifdef SIMD_CMP_MASK_EN
        out_mask <= mg_mask;
`endif
      end
    end
  end

endmodule

// File: tb/tb_simd_cmp_pipe.sv
// Directed self-checking bench for simd_cmp_pipe (WIDTH=256, TAG_W=4).
module tb_simd_cmp_pipe;

  localparam int unsigned WIDTH = 256;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned NB    = WIDTH / 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a, in_b;
  logic [2:0]         in_mode;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_res;
  logic [TAG_W-1:0]   out_tag;
`ifdef SIMD_CMP_MASK_EN
  logic [NB-1:0]      out_mask;
`endif

  int total = 0;
  int bad   = 0;

  simd_cmp_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
`ifdef SIMD_CMP_MASK_EN
    ,
    .out_mask  (out_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One beat through an empty pipe: accept edge, output valid one edge later.
  task automatic one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [2:0] mode, input logic [1:0] op, input logic [TAG_W-1:0] t,
                     input logic [WIDTH-1:0] exp_res, input logic [NB-1:0] exp_mask);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; in_op = op; in_tag = t;
    out_ready = 1'b1;
    chk({tag, "_rdy"}, WIDTH'(in_ready), WIDTH'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat"}, WIDTH'(out_valid), WIDTH'(0));
    @(negedge clk);
    chk({tag, "_vld"}, WIDTH'(out_valid), WIDTH'(1));
    chk({tag, "_res"}, out_res, exp_res);
    chk({tag, "_tag"}, WIDTH'(out_tag), WIDTH'(t));
`ifdef SIMD_CMP_MASK_EN
    chk({tag, "_msk"}, WIDTH'(out_mask), WIDTH'(exp_mask));
`else
    if (exp_mask !== exp_mask) chk({tag, "_msk"}, '0, '1);
`endif
  endtask

  logic [WIDTH-1:0] ones, p55, a_v, b_v, held_res;
  logic [TAG_W-1:0] held_tag;
  logic [7:0]       stream_exp;
  logic             prev_stall;
  int               sent, rcv, cyc;

  initial begin
    ones = '1;
    p55  = {32{8'h55}};
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_op = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vld", WIDTH'(out_valid), WIDTH'(0));
    chk("rst_res", out_res, '0);
    chk("rst_tag", WIDTH'(out_tag), WIDTH'(0));
`ifdef SIMD_CMP_MASK_EN
    chk("rst_msk", WIDTH'(out_mask), WIDTH'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", WIDTH'(in_ready), WIDTH'(1));

    one("eq8", p55, p55, 3'd0, 2'd0, 4'd1, ones, 32'hFFFF_FFFF);
    one("gts8", {32{8'h80}}, {32{8'h7F}}, 3'd0, 2'd1, 4'd2, '0, 32'h0);
    one("gtu8", {32{8'h80}}, {32{8'h7F}}, 3'd0, 2'd2, 4'd3, ones, 32'hFFFF_FFFF);

    a_v = {{7{32'h1234_5678}}, 32'hFFFF_FFFF};
    b_v = {{7{32'h1234_5678}}, 32'h0000_0001};
    one("lts32", a_v, b_v, 3'd2, 2'd3, 4'd4, {224'd0, 32'hFFFF_FFFF}, 32'h1);

    one("mnmp_gts", {8{32'h8000_0000}}, {8{32'h7FFF_FFFF}}, 3'd2, 2'd1, 4'd5, '0, 32'h0);
    one("mnmp_gtu", {8{32'h8000_0000}}, {8{32'h7FFF_FFFF}}, 3'd2, 2'd2, 4'd6, ones, 32'hFF);

    // High byte decides against the low byte inside a 16-bit lane.
    a_v = {{15{16'h1111}}, 16'h0100};
    b_v = {{15{16'h1111}}, 16'h00FF};
    one("gtu16", a_v, b_v, 3'd1, 2'd2, 4'd7, {240'd0, 16'hFFFF}, 32'h1);
    a_v = {{15{16'h1111}}, 16'hFF00};
    one("lts16", a_v, b_v, 3'd1, 2'd3, 4'd8, {240'd0, 16'hFFFF}, 32'h1);
    one("gts16", a_v, b_v, 3'd1, 2'd1, 4'd9, '0, 32'h0);

    a_v = {8{32'hDEAD_BEEF}};
    one("eqop_lts", a_v, a_v, 3'd3, 2'd3, 4'd10, '0, 32'h0);
    one("eqop_gts", a_v, a_v, 3'd1, 2'd1, 4'd11, '0, 32'h0);
    one("eqop_eq", a_v, a_v, 3'd4, 2'd0, 4'd12, ones, 32'h3);

    a_v = {1'b1, 255'd0};
    one("m5_gts", a_v, '0, 3'd5, 2'd1, 4'd13, '0, 32'h0);
    one("m7_gts", a_v, '0, 3'd7, 2'd1, 4'd14, '0, 32'h0);
    one("m5_gtu", a_v, '0, 3'd5, 2'd2, 4'd15, ones, 32'h1);
    one("m6_eq", a_v, '0, 3'd6, 2'd0, 4'd0, '0, 32'h0);

    // Stream 8 beats vs B=0x02 bytes; even beats EQ, odd beats GTU.
    stream_exp = 8'hAC;
    sent = 0; rcv = 0; cyc = 0; prev_stall = 1'b0;
    held_res = '0; held_tag = '0;
    while (rcv < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = sent < 8;
      in_a      = {32{8'(sent)}};
      in_b      = {32{8'h02}};
      in_mode   = 3'd0;
      in_op     = sent[0] ? 2'd2 : 2'd0;
      in_tag    = TAG_W'(sent);
      #1;
      if (prev_stall) begin
        chk("hold_res", out_res, held_res);
        chk("hold_tag", WIDTH'(out_tag), WIDTH'(held_tag));
      end
      if (out_valid && out_ready) begin
        chk("strm_tag", WIDTH'(out_tag), WIDTH'(rcv));
        chk("strm_res", out_res, stream_exp[rcv] ? ones : '0);
        rcv++;
      end
      prev_stall = out_valid && !out_ready;
      held_res   = out_res;
      held_tag   = out_tag;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("strm_cnt", WIDTH'(rcv), WIDTH'(8));
    repeat (3) @(negedge clk);
    chk("strm_nodup", WIDTH'(out_valid), WIDTH'(0));

    // Reset with two beats in flight.
    @(negedge clk);
    in_valid = 1'b1; in_a = p55; in_b = p55; in_mode = 3'd0; in_op = 2'd0; in_tag = 4'd9;
    @(negedge clk);
    in_tag = 4'd10;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mrst_vld", WIDTH'(out_valid), WIDTH'(0));
    chk("mrst_res", out_res, '0);
    chk("mrst_tag", WIDTH'(out_tag), WIDTH'(0));
    chk("mrst_rdy", WIDTH'(in_ready), WIDTH'(1));
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_stale", WIDTH'(out_valid), WIDTH'(0));
    end
    one("post_rst", {32{8'h10}}, {32{8'h20}}, 3'd0, 2'd3, 4'd3, ones, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
